run_trace_monitor: RTL
======================

# run_trace_monitor

- Run controller and execution-trace recorder for the pipelined datapath core.
- Generates the core's reset window and counts run cycles.
- Records every program-counter change, with the other monitored channels, into a circular buffer, and flags halt when the PC stops moving.
- Sits between the bench or FPGA debug logic and the core's PC / write-data / Hi / Lo outputs; trace contents are readable after a run.

## Interface
- DATA_W, 32, width of each monitored channel
- NUM_CH, 4, channel count; channel 0 is always PC
- DEPTH, 16, trace entries (power of two, ≥2)
- HOLD_CYCLES, 3, cycles CoreRst is held high after Start (≥1)
- HALT_CYCLES, 8, consecutive cycles of unchanged PC that declare halt (≥2)
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  begin or restart a run (sampled in IDLE and HALT only)
- Mon_in  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- CoreRst  out  1  active-high reset to the core
- Running  out  1  high in RUN
- Halted  out  1  high in HALT
- CycleCount  out  32  RUN cycles since the last Start, saturating
- Trace_count  out  $clog2(DEPTH)+1  valid entries, max DEPTH
- Wrapped  out  1  at least one entry has been overwritten
- Rd_en  in  1  read request
- Rd_addr  in  $clog2(DEPTH)  logical index, 0 = oldest entry
- Rd_ch  in  $clog2(NUM_CH+1)  channel select
- Rd_data  out  DATA_W  registered read data
- Rd_valid  out  1  pulses one cycle after Rd_en

## Operation
- FSM states: IDLE, HOLD, RUN, HALT.
- IDLE: CoreRst=1. Start → HOLD.
  - Entering HOLD clears Trace_count, the write pointer, Wrapped, CycleCount and the halt counter.
  - The hold counter loads HOLD_CYCLES.
- HOLD: CoreRst=1; the counter decrements each cycle; at 1 → RUN.
- RUN: CoreRst=0, Running=1, CycleCount increments each cycle and saturates at 0xFFFFFFFF.
  - Capture condition: first RUN cycle, or PC (channel 0) ≠ last captured PC.
  - On capture, all NUM_CH channels are written at the write pointer.
  - Write pointer wraps modulo DEPTH.
  - Trace_count saturates at DEPTH; a write while Trace_count==DEPTH sets Wrapped.
  - Halt counter: PC equal to the previous cycle's PC increments it, otherwise it clears to 0. Reaching HALT_CYCLES-1 → HALT.
  - Start is ignored in RUN.
- HALT: Halted=1, CoreRst=0, no captures, CycleCount frozen. Start → HOLD, with the HOLD-entry clears above.
- Read port, active in any state:
  - Physical address = (oldest + Rd_addr) mod DEPTH.
  - Oldest = write pointer when Wrapped, else 0.
  - Rd_addr ≥ Trace_count or Rd_ch ≥ NUM_CH returns 0 (see Configuration).
  - A read of the entry being written in the same cycle returns the pre-write contents.

## Timing
- Reset (Rst low, asynchronous) values:
  - state IDLE, CoreRst=1, Running=0, Halted=0;
  - CycleCount=0, Trace_count=0, Wrapped=0, Rd_data=0, Rd_valid=0.
  - Buffer RAM is not reset.
- Rst asserted mid-run aborts immediately to IDLE; release is synchronous to the next edge.
- Start sampled at edge t: CoreRst stays high through edge t+HOLD_CYCLES. The first RUN cycle begins after that edge.
- Capture latency: Trace_count and the entry update on the edge that samples Mon_in.
- Halt: with the PC constant from RUN cycle n, Halted rises at the edge ending cycle n+HALT_CYCLES-1. Running falls on the same edge.
- Read latency: 1 cycle. Rd_valid=1 exactly one cycle after each Rd_en, including for out-of-range reads. Back-to-back reads are allowed every cycle.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - Each entry also stores CycleCount[DATA_W-1:0] at capture.
  - Rd_ch==NUM_CH returns that timestamp.
- TRACE_TIMESTAMP_EN undefined:
  - No timestamp storage.
  - Rd_ch==NUM_CH returns 0.
  - Port widths are unchanged.

## Test plan
- Reset and hold, with HOLD_CYCLES=3:
  - Rst low → all outputs at the reset values above.
  - Release, then Start pulse → CoreRst high for exactly 3 edges after Start, then Running=1 and CycleCount=1 one edge later.
- Linear PC trace:
  - PC steps 0,4,8,…,28 one per cycle, then holds at 28.
  - → Trace_count=8.
  - Reading Rd_addr 0..7 on ch0 gives 0,4,…,28.
  - Halted=1 after 8 cycles at 28.
- Wrap-around, with DEPTH=16:
  - 20 distinct PCs 0x100..0x14C step 4.
  - → Trace_count=16, Wrapped=1.
  - Rd_addr 0 returns 0x110; Rd_addr 15 returns 0x14C.
- Multi-channel and out-of-range reads:
  - Capture Hi=0xDEAD_BEEF on ch2 with PC=0x40 as entry 0 → Rd_ch=2, Rd_addr=0 returns 0xDEADBEEF.
  - Rd_addr ≥ Trace_count → 0 with Rd_valid=1.
- Restart and abort:
  - Start in HALT → counters and Wrapped clear, HOLD re-entered.
  - Rst low during RUN → IDLE, CoreRst=1, Trace_count=0 in the same cycle.
- With TRACE_TIMESTAMP_EN: PC changes at RUN cycles 1, 5, 9 → Rd_ch=NUM_CH returns stamps 1, 5, 9.

Source files
------------

// File: rtl/run_trace_monitor_if.sv
// Read-port bundle for run_trace_monitor.
//   master : debug side. Drives Rd_en, Rd_addr and Rd_ch, and receives Rd_data and Rd_valid.
//   slave  : monitor side. This is the mirror image of the master modport.
// Rd_addr is a logical index where 0 is the oldest trace entry.
// Rd_ch selects a channel. The value NUM_CH selects the timestamp when that feature is built in.
interface run_trace_monitor_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = $clog2(NUM_CH + 1);

  logic              Rd_en;
  logic [ADDR_W-1:0] Rd_addr;
  logic [CH_W-1:0]   Rd_ch;
  logic [DATA_W-1:0] Rd_data;
  logic              Rd_valid;

  modport master (output Rd_en, Rd_addr, Rd_ch, input Rd_data, Rd_valid);
  modport slave  (input Rd_en, Rd_addr, Rd_ch, output Rd_data, Rd_valid);
endinterface

// File: rtl/run_trace_monitor.sv
// run_trace_monitor: run controller and execution-trace recorder for the datapath core.
//
// Run control:
//   - Holds the core in reset for HOLD_CYCLES after Start.
//   - Counts RUN cycles in CycleCount, which saturates.
//   - Declares halt once the PC (channel 0) has stayed unchanged for HALT_CYCLES cycles.
//
// Trace capture:
//   - Every PC change is captured with all NUM_CH channels into a DEPTH-entry circular buffer.
//   - The first RUN cycle is always captured.
//
// Ports:
//   Clk, Rst     : clock; asynchronous active-low reset.
//   Start        : begin or restart a run. Sampled in IDLE and HALT only.
//   Mon_in       : monitored channels. Channel k is at [k*DATA_W +: DATA_W]; channel 0 is the PC.
//   CoreRst      : active-high reset to the core (IDLE and HOLD).
//   Running      : high in RUN.
//   Halted       : high in HALT.
//   CycleCount   : RUN cycles since the last Start.
//   Trace_count  : number of valid entries.
//   Wrapped      : high once any entry has been overwritten.
//   rd           : read port (run_trace_monitor_if.slave). Registered, 1-cycle latency.
//
// Optional feature, macro TRACE_TIMESTAMP_EN:
//   - When defined, each entry also stores the low DATA_W bits of CycleCount, taken from the capturing cycle.
//   - Rd_ch == NUM_CH then returns that timestamp.
//   - Without the macro, Rd_ch == NUM_CH reads as 0.
module run_trace_monitor #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 3,
  parameter int HALT_CYCLES = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [NUM_CH*DATA_W-1:0] Mon_in,
  output logic                     CoreRst,
  output logic                     Running,
  output logic                     Halted,
  output logic [31:0]              CycleCount,
  output logic [$clog2(DEPTH):0]   Trace_count,
  output logic                     Wrapped,
  run_trace_monitor_if.slave       rd
);

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int CNT_W    = ADDR_W + 1;
  localparam int CH_W     = $clog2(NUM_CH + 1);
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int HALT_W   = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, HALT} state_t;

  state_t state_q, state_d;

  logic [HOLD_W-1:0] hold_cnt;
  logic [HALT_W-1:0] halt_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              run_seen;
  logic [DATA_W-1:0] last_pc;
  logic [DATA_W-1:0] pc;
  logic              pc_same;
  logic              capture;
  logic              halt_hit;
  logic              enter_hold;
  logic [31:0]       cyc_next;

  logic [DATA_W-1:0] mem [DEPTH][NUM_CH];
`ifdef TRACE_TIMESTAMP_EN
  logic [DATA_W-1:0] ts_mem [DEPTH];
`endif

  logic [ADDR_W-1:0] oldest;
  logic [ADDR_W-1:0] phys;
  logic              in_range;
  logic [DATA_W-1:0] rd_word_p0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc       = Mon_in[DATA_W-1:0];
  assign cyc_next = sat_inc(CycleCount);

  // Every PC change is captured, so last_pc is both the last captured PC
  // and the previous RUN cycle's PC.
  assign pc_same    = run_seen && (pc == last_pc);
  assign capture    = (state_q == RUN) && !pc_same;
  assign halt_hit   = (state_q == RUN) && pc_same && (halt_cnt == HALT_W'(HALT_CYCLES - 2));
  assign enter_hold = Start && ((state_q == IDLE) || (state_q == HALT));

  assign CoreRst = (state_q == IDLE) || (state_q == HOLD);
  assign Running = (state_q == RUN);
  assign Halted  = (state_q == HALT);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = HOLD;
      HOLD:    if (hold_cnt == HOLD_W'(1)) state_d = RUN;
      RUN:     if (halt_hit) state_d = HALT;
      HALT:    if (Start) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hold_cnt    <= '0;
      halt_cnt    <= '0;
      run_seen    <= 1'b0;
      CycleCount  <= '0;
      Trace_count <= '0;
      wr_ptr      <= '0;
      Wrapped     <= 1'b0;
    end else if (enter_hold) begin
      hold_cnt    <= HOLD_W'(HOLD_CYCLES);
      halt_cnt    <= '0;
      run_seen    <= 1'b0;
      CycleCount  <= '0;
      Trace_count <= '0;
      wr_ptr      <= '0;
      Wrapped     <= 1'b0;
    end else begin
      if (state_q == HOLD) hold_cnt <= hold_cnt - HOLD_W'(1);
      if (state_q == RUN) begin
        run_seen   <= 1'b1;
        CycleCount <= cyc_next;
        halt_cnt   <= pc_same ? halt_cnt + HALT_W'(1) : '0;
        if (capture) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (Trace_count == CNT_W'(DEPTH)) Wrapped <= 1'b1;
          else                              Trace_count <= Trace_count + CNT_W'(1);
        end
      end
    end
  end

  // Trace storage and PC history carry no reset; run_seen masks last_pc until it is valid.
  always_ff @(posedge Clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_CH; k++) mem[wr_ptr][k] <= Mon_in[k*DATA_W +: DATA_W];
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wr_ptr] <= DATA_W'(cyc_next);
`endif
    end
    if (state_q == RUN) last_pc <= pc;
  end

  // Read stage p0: map the logical index onto the ring and select the channel.
  assign oldest   = Wrapped ? wr_ptr : '0;
  assign phys     = oldest + rd.Rd_addr;
  assign in_range = {1'b0, rd.Rd_addr} < Trace_count;

  always_comb begin
    rd_word_p0 = '0;
    if (in_range) begin
      if (rd.Rd_ch < CH_W'(NUM_CH)) rd_word_p0 = mem[phys][rd.Rd_ch[CH_IDX_W-1:0]];
`ifdef TRACE_TIMESTAMP_EN
      else if (rd.Rd_ch == CH_W'(NUM_CH)) rd_word_p0 = ts_mem[phys];
`endif
    end
  end

  // Read stage p1: registered output. A read of the slot written this cycle sees the old contents.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd.Rd_data  <= '0;
      rd.Rd_valid <= 1'b0;
    end else begin
      rd.Rd_valid <= rd.Rd_en;
      if (rd.Rd_en) rd.Rd_data <= rd_word_p0;
    end
  end

endmodule
